// File: rtl/d_mem_port_rv_pkg.sv
// Shared definitions for the memory-stage load/store port.
// Access-size encodings, FSM state codes and timeout counter width.
package d_mem_port_rv_pkg;

  localparam logic [1:0] MEM_ACCESS_BYTE      = 2'b00;
  localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'b01;
  localparam logic [1:0] MEM_ACCESS_WORD      = 2'b10;

  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_FAULT
  } dMemState_e;

endpackage

// File: rtl/d_mem_lane_gen_rv.sv
// Byte-lane generator: byte enables, lane-replicated store data
// and alignment check from access size and low address bits.
module d_mem_lane_gen_rv
  import d_mem_port_rv_pkg::*;
(
  input  logic [1:0]  iwSize,
  input  logic [1:0]  iwAddrLo,
  input  logic [31:0] iwData,
  output logic [3:0]  owByteEn,
  output logic [31:0] owWData,
  output logic        owMisaligned
);

  always_comb begin
    owByteEn     = 4'b0000;
    owWData      = 32'd0;
    owMisaligned = 1'b0;
    unique case (1'b1)
      (iwSize == MEM_ACCESS_BYTE): begin
        owByteEn = 4'b0001 << iwAddrLo;
        owWData  = {4{iwData[7:0]}};
      end
      (iwSize == MEM_ACCESS_HALF_WORD): begin
        owByteEn     = 4'b0011 << iwAddrLo;
        owWData      = {2{iwData[15:0]}};
        owMisaligned = iwAddrLo[0];
      end
      // word and the unused encoding both take full-word rules
      default: begin
        owByteEn     = 4'b1111;
        owWData      = iwData;
        owMisaligned = |iwAddrLo;
      end
    endcase
  end

endmodule

// File: rtl/d_mem_port_rv.sv
// Memory-stage load/store port: req/ack bus handshake, pipeline
// stall, ack timeout and capture of the raw read word.
module d_mem_port_rv
  import d_mem_port_rv_pkg::*;
#(
  parameter int P_TIMEOUT = 255
) (
  input  logic        iwClk,
  input  logic        iwReset,
  input  logic        iwValid,
  input  logic        iwWrite,
  input  logic [31:0] iwAddress,
  input  logic [31:0] iwWriteData,
  input  logic [1:0]  iwDMemAccess,
  input  logic        iwDMemSignExtend,
  output logic        owStall,
  output logic        owMemReq,
  output logic        owMemWe,
  output logic [31:0] owMemAddr,
  output logic [31:0] owMemWData,
  output logic [3:0]  owMemByteEn,
  input  logic        iwMemAck,
  input  logic [31:0] iwMemRData,
  output logic        owValid,
  output logic        owIsLoad,
  output logic [31:0] owValue,
  output logic [31:0] owAddress,
  output logic [1:0]  owDMemAccess,
  output logic        owDMemSignExtend,
  output logic        owMisaligned,
  output logic        owBusError
);

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT =
    TIMEOUT_W'(P_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TO_ONE = TIMEOUT_W'(1);

  dMemState_e state;
  dMemState_e stateNext;

  logic [TIMEOUT_W-1:0] toCnt;
  logic                 toErr;

  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic [3:0]  reqByteEn;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqSign;

  logic [3:0]  laneByteEn;
  logic [31:0] laneWData;
  logic        laneMis;

  logic accept;
  logic finish;
  logic expire;

  d_mem_lane_gen_rv uLaneGen (
    .iwSize       (iwDMemAccess),
    .iwAddrLo     (iwAddress[1:0]),
    .iwData       (iwWriteData),
    .owByteEn     (laneByteEn),
    .owWData      (laneWData),
    .owMisaligned (laneMis)
  );

  always_comb begin
    stateNext    = state;
    accept       = 1'b0;
    finish       = 1'b0;
    expire       = 1'b0;
    owStall      = 1'b0;
    owMemReq     = 1'b0;
    owValid      = 1'b0;
    owBusError   = 1'b0;
    owMisaligned = 1'b0;
    unique case (state)
      ST_IDLE: begin
        owStall = iwValid;
        if (iwValid) begin
          if (laneMis) begin
            stateNext = ST_FAULT;
          end else begin
            stateNext = ST_BUSY;
            accept    = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        owStall  = 1'b1;
        owMemReq = 1'b1;
        // an ack on the limit cycle still completes normally
        if (iwMemAck) begin
          finish = 1'b1;
        end else if (toCnt == TO_LIMIT) begin
          finish = 1'b1;
          expire = 1'b1;
        end
        if (finish) stateNext = ST_RESP;
      end
      ST_RESP: begin
        owValid    = 1'b1;
        owBusError = toErr;
        stateNext  = ST_IDLE;
      end
      ST_FAULT: begin
        owMisaligned = 1'b1;
        stateNext    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iwClk) begin
    if (iwReset) begin
      state            <= ST_IDLE;
      toCnt            <= '0;
      toErr            <= 1'b0;
      reqAddr          <= '0;
      reqWData         <= '0;
      reqByteEn        <= '0;
      reqWe            <= 1'b0;
      reqSize          <= '0;
      reqSign          <= 1'b0;
      owIsLoad         <= 1'b0;
      owValue          <= '0;
      owAddress        <= '0;
      owDMemAccess     <= '0;
      owDMemSignExtend <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        reqAddr   <= iwAddress;
        reqWData  <= laneWData;
        reqByteEn <= laneByteEn;
        reqWe     <= iwWrite;
        reqSize   <= iwDMemAccess;
        reqSign   <= iwDMemSignExtend;
        toCnt     <= '0;
      end else if ((state == ST_BUSY) && !iwMemAck) begin
        toCnt <= toCnt + TO_ONE;
      end
      if (finish) begin
        toErr            <= expire;
        owIsLoad         <= !reqWe;
        owValue          <= (iwMemAck && !reqWe) ? iwMemRData : '0;
        owAddress        <= reqAddr;
        owDMemAccess     <= reqSize;
        owDMemSignExtend <= reqSign;
      end
    end
  end

  assign owMemWe     = reqWe;
  assign owMemAddr   = {reqAddr[31:2], 2'b00};
  assign owMemWData  = reqWData;
  assign owMemByteEn = reqByteEn;

endmodule
